// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request channel to single APB transfers.
// One transfer in flight; hung transfers abort with an error after TIMEOUT.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pwstrb,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic TO_EN = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pwstrb_q, pwstrb_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  assign req_ready = (state_q == IDLE);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pwstrb    = pwstrb_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pwstrb_d    = pwstrb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pwstrb_d = req_write ? req_wstrb : '0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops the bus at once.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pwstrb_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pwstrb_q    <= pwstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of apb_master_bridge.
// Bridge built with a 4-cycle timeout so the abort path is short.
module tb_apb_master_bridge;

  localparam int P_ADDR_W = 32;
  localparam int P_DATA_W = 32;
  localparam int P_STRB_W = 4;

  logic                pclk = 1'b0;
  logic                preset;
  logic                req_valid;
  logic                req_ready;
  logic [P_ADDR_W-1:0] req_addr;
  logic                req_write;
  logic [P_DATA_W-1:0] req_wdata;
  logic [P_STRB_W-1:0] req_wstrb;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [P_DATA_W-1:0] rsp_rdata;
  logic                rsp_err;
  logic [P_ADDR_W-1:0] paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [P_DATA_W-1:0] pwdata;
  logic [P_STRB_W-1:0] pwstrb;
  logic                pready;
  logic [P_DATA_W-1:0] prdata;
  logic                pslverr;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_bridge #(
    .ADDR_W (P_ADDR_W),
    .DATA_W (P_DATA_W),
    .STRB_W (P_STRB_W),
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .pwstrb   (pwstrb),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_wstrb = s;
  endtask

  initial begin
    preset    = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    step();
    step();
    chk("rst_psel", psel, 0);
    chk("rst_pen", penable, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwstrb", pwstrb, 0);
    chk("rst_rdy", req_ready, 1);
    preset = 1'b0;

    // zero-wait write
    req(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF);
    pready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("w_psel0", psel, 1);
    chk("w_pen0", penable, 0);
    chk("w_paddr", paddr, 32'h1000_0004);
    chk("w_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("w_pwstrb", pwstrb, 4'hF);
    chk("w_pwrite", pwrite, 1);
    chk("w_rdy0", req_ready, 0);
    step();
    chk("w_psel1", psel, 1);
    chk("w_pen1", penable, 1);
    chk("w_rspv1", rsp_valid, 0);
    step();
    chk("w_psel2", psel, 0);
    chk("w_pen2", penable, 0);
    chk("w_rspv2", rsp_valid, 1);
    chk("w_err", rsp_err, 0);
    chk("w_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w_rspv3", rsp_valid, 0);
    chk("w_rdy3", req_ready, 1);

    // read, 3 wait states, response backpressure
    pready = 1'b0;
    prdata = 32'h1234_5678;
    req(32'h2000_0008, 1'b0, 32'hFFFF_FFFF, 4'hF);
    step();
    req_valid = 1'b0;
    chk("r_pwstrb", pwstrb, 0);
    chk("r_pwrite", pwrite, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_wait_pen", penable, 1);
      chk("r_wait_addr", paddr, 32'h2000_0008);
      chk("r_wait_strb", pwstrb, 0);
      chk("r_wait_rspv", rsp_valid, 0);
    end
    step();
    pready = 1'b1;
    chk("r_acc4_rspv", rsp_valid, 0);
    step();
    pready = 1'b0;
    prdata = 32'hCAFE_0000;
    chk("r_rspv", rsp_valid, 1);
    chk("r_rdata", rsp_rdata, 32'h1234_5678);
    chk("r_pen_off", penable, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("r_hold_v", rsp_valid, 1);
      chk("r_hold_d", rsp_rdata, 32'h1234_5678);
      chk("r_hold_rdy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("r_done_v", rsp_valid, 0);
    chk("r_done_rdy", req_ready, 1);

    // slave error, next request right after handshake
    req(32'h3000_0000, 1'b1, 32'h0000_0055, 4'h1);
    pready  = 1'b1;
    pslverr = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("e_rspv", rsp_valid, 1);
    chk("e_err", rsp_err, 1);
    pslverr   = 1'b0;
    prdata    = 32'hA5A5_0001;
    rsp_ready = 1'b1;
    req(32'h3000_0010, 1'b0, 32'h0, 4'h0);
    step();
    rsp_ready = 1'b0;
    chk("e_hs_psel", psel, 0);
    chk("e_hs_rdy", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("e_next_psel", psel, 1);
    chk("e_next_addr", paddr, 32'h3000_0010);
    step();
    step();
    chk("e_next_rspv", rsp_valid, 1);
    chk("e_next_err", rsp_err, 0);
    chk("e_next_rd", rsp_rdata, 32'hA5A5_0001);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // timeout with pready held low
    pready = 1'b0;
    req(32'hF000_0000, 1'b0, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t_pen", penable, 1);
      chk("t_rspv", rsp_valid, 0);
    end
    step();
    chk("t_pen_off", penable, 0);
    chk("t_psel_off", psel, 0);
    chk("t_rspv1", rsp_valid, 1);
    chk("t_err", rsp_err, 1);
    chk("t_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    pready = 1'b1;
    prdata = 32'h0BAD_F00D;
    req(32'h4000_0000, 1'b0, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("t2_rspv", rsp_valid, 1);
    chk("t2_err", rsp_err, 0);
    chk("t2_rd", rsp_rdata, 32'h0BAD_F00D);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // asynchronous reset during ACCESS
    pready = 1'b0;
    req(32'h5000_0000, 1'b1, 32'h1111_2222, 4'h3);
    step();
    req_valid = 1'b0;
    step();
    chk("a_pen_pre", penable, 1);
    #2;
    preset = 1'b1;
    #1;
    chk("a_psel", psel, 0);
    chk("a_pen", penable, 0);
    chk("a_rspv", rsp_valid, 0);
    chk("a_rdy", req_ready, 1);
    #1;
    preset = 1'b0;
    step();
    chk("a_rdy2", req_ready, 1);
    chk("a_psel2", psel, 0);

    // back-to-back reads with rsp_ready tied high
    rsp_ready = 1'b1;
    pready    = 1'b1;
    prdata    = 32'h0000_00A1;
    req(32'h6000_0100, 1'b0, 32'h0, 4'h0);
    step();
    chk("b1_setup_addr", paddr, 32'h6000_0100);
    req_addr = 32'h6000_0200;
    step();
    chk("b1_acc_addr", paddr, 32'h6000_0100);
    chk("b1_acc_pen", penable, 1);
    step();
    chk("b1_rspv", rsp_valid, 1);
    chk("b1_rd", rsp_rdata, 32'h0000_00A1);
    step();
    chk("b1_hs_psel", psel, 0);
    chk("b1_hs_v", rsp_valid, 0);
    step();
    req_valid = 1'b0;
    prdata = 32'h0000_00B2;
    chk("b2_psel", psel, 1);
    chk("b2_setup_addr", paddr, 32'h6000_0200);
    step();
    chk("b2_acc_addr", paddr, 32'h6000_0200);
    step();
    chk("b2_rspv", rsp_valid, 1);
    chk("b2_rd", rsp_rdata, 32'h0000_00B2);
    step();
    chk("b2_idle", req_ready, 1);
    rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
